// File: rtl/serial_subtractor.sv
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial WIDTH-bit subtractor, diff = a - b - borrow_in,
//               one bit per clock, LSB first. The borrow is carried between
//               cycles in a single flip-flop. Operands are accepted and
//               results returned over valid/ready handshakes.
//               Optional feature macro: SERIAL_SUB_OVF_EN adds the signed
//               overflow output 'ovf'.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             done_valid,
   input  logic             done_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
`ifdef SERIAL_SUB_OVF_EN
   output logic             ovf,
`endif
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] a_sh_q;
   logic [WIDTH-1:0] b_sh_q;
   logic [WIDTH-1:0] res_q;
   logic             br_q;
   logic [WIDTH-1:0] diff_q;
   logic             borrow_out_q;
   logic             start_ready_q;
   logic             done_valid_q;
   logic             busy_q;

   logic             a_bit_w;
   logic             b_bit_w;
   logic             d_bit_w;
   logic             br_d;
   logic [WIDTH-1:0] res_d;

`ifdef SERIAL_SUB_OVF_EN
   logic             ovf_q;
   logic             ovf_d;
`endif

   // One full-subtractor slice operating on the current LSBs of the shift regs.
   always_comb begin
      a_bit_w = a_sh_q[0];
      b_bit_w = b_sh_q[0];
      d_bit_w = a_bit_w ^ b_bit_w ^ br_q;
      br_d    = (~a_bit_w & b_bit_w) | (~(a_bit_w ^ b_bit_w) & br_q);
      res_d   = {d_bit_w, res_q[WIDTH-1:1]};
`ifdef SERIAL_SUB_OVF_EN
      // On the final slice the shift-reg LSBs are the original operand MSBs
      // and d_bit_w is the result MSB, so no extra operand storage is needed.
      ovf_d   = (a_bit_w != b_bit_w) & (d_bit_w != a_bit_w);
`endif
   end

   // Control FSM plus datapath registers; all outputs come straight from flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         count_q       <= '0;
         a_sh_q        <= '0;
         b_sh_q        <= '0;
         res_q         <= '0;
         br_q          <= 1'b0;
         diff_q        <= '0;
         borrow_out_q  <= 1'b0;
         start_ready_q <= 1'b1;
         done_valid_q  <= 1'b0;
         busy_q        <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q         <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (start_valid) begin
                  a_sh_q        <= a;
                  b_sh_q        <= b;
                  br_q          <= borrow_in;
                  count_q       <= '0;
                  state_q       <= RUN;
                  start_ready_q <= 1'b0;
                  busy_q        <= 1'b1;
               end
            end
            RUN: begin
               a_sh_q <= a_sh_q >> 1;
               b_sh_q <= b_sh_q >> 1;
               br_q   <= br_d;
               res_q  <= res_d;
               if (count_q == LAST) begin
                  diff_q       <= res_d;
                  borrow_out_q <= br_d;
`ifdef SERIAL_SUB_OVF_EN
                  ovf_q        <= ovf_d;
`endif
                  done_valid_q <= 1'b1;
                  state_q      <= DONE;
               end else begin
                  count_q <= count_q + 1'b1;
               end
            end
            DONE: begin
               // No bypass: start_ready only returns once back in IDLE.
               if (done_ready) begin
                  done_valid_q  <= 1'b0;
                  start_ready_q <= 1'b1;
                  busy_q        <= 1'b0;
                  state_q       <= IDLE;
               end
            end
            default: begin
               state_q       <= IDLE;
               start_ready_q <= 1'b1;
               done_valid_q  <= 1'b0;
               busy_q        <= 1'b0;
            end
         endcase
      end
   end

   assign start_ready = start_ready_q;
   assign done_valid  = done_valid_q;
   assign busy        = busy_q;
   assign diff        = diff_q;
   assign borrow_out  = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf         = ovf_q;
`endif

endmodule

`default_nettype wire
